// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of the async FIFO write side.
// Grants bounded bursts, gates writes on full, counts wr_er pulses.
module fifo_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int BURST = 4,
    parameter int CNTW  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [IDW-1:0]        owner,
    output logic                  busy,
    output logic                  wr_en,
    output logic [WIDTH-1:0]      wr_data,
    input  logic                  full,
    input  logic                  wr_er,
    output logic [CNTW-1:0]       err_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   w_gnt_nxt;
    logic [IDW-1:0]    r_owner;
    logic [IDW-1:0]    w_owner_nxt;
    logic [IDW-1:0]    r_last;
    logic [IDW-1:0]    w_last_nxt;
    logic [7:0]        r_beat;
    logic [7:0]        w_beat_nxt;
    logic [CNTW-1:0]   r_err_cnt;

    logic              w_found;
    logic [IDW-1:0]    w_sel;
    logic [NREQ-1:0]   w_sel_oh;
    logic              w_own_req;
    logic [WIDTH-1:0]  w_own_data;
    logic              w_wr;
    logic              w_last_beat;

    // Search upward from the slot after the last owner, with wrap-around.
    always_comb begin
        int w_idx;
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_last) + k) % NREQ;
            if (!w_found && (|(req & (NREQ'(1) << w_idx)))) begin
                w_found = 1'b1;
                w_sel   = IDW'(w_idx);
            end
        end
    end

    assign w_sel_oh  = NREQ'(1) << w_sel;
    assign w_own_req = |(req & r_gnt);

    always_comb begin
        w_own_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_own_data = w_own_data | req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_wr        = (r_state == XFER) && w_own_req && !full;
    assign w_last_beat = (r_beat == 8'(BURST - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_beat_nxt  = r_beat;
        wr_en       = 1'b0;
        wr_data     = '0;
        ack         = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = XFER;
                    w_gnt_nxt   = w_sel_oh;
                    w_owner_nxt = w_sel;
                    w_beat_nxt  = '0;
                end
            end
            XFER: begin
                wr_en = w_wr;
                if (w_wr) begin
                    wr_data    = w_own_data;
                    ack        = r_gnt;
                    w_beat_nxt = r_beat + 8'd1;
                end
                if (!w_own_req || (w_wr && w_last_beat)) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_owner;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_beat  <= '0;
            r_last  <= IDW'(NREQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_beat  <= w_beat_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cnt <= '0;
        end else if (wr_er && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + CNTW'(1);
        end
    end

    assign gnt     = r_gnt;
    assign owner   = r_owner;
    assign busy    = (r_state == XFER);
    assign err_cnt = r_err_cnt;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the asynchronous FIFO among NREQ requesters, all in the FIFO write-clock domain. It grants one requester at a time for a bounded burst of up to BURST words, gates every write on the FIFO full flag, and counts write errors reported back by the FIFO. It sits directly in front of the FIFO wr_en/wr_data/full/wr_er pins.

Parameters:
WIDTH, 8, data word width; matches the FIFO WIDTH
NREQ, 4, number of requesters (2..8)
IDW, 2, owner index width; must satisfy 2^IDW >= NREQ
BURST, 4, maximum words per grant tenure (1..255)
CNTW, 8, error counter width

Ports:
clk  in  1  write-side clock; the same clock as the FIFO wr_clk
rst  in  1  asynchronous, active-low reset
req  in  NREQ  per-requester write request; bit i belongs to requester i
req_data  in  NREQ*WIDTH  flattened request data; slice [i*WIDTH +: WIDTH] belongs to requester i
gnt  out  NREQ  one-hot grant, registered
ack  out  NREQ  one-hot; word from requester i accepted this cycle
owner  out  IDW  index of the current or most recent grant holder
busy  out  1  high while the FSM is in XFER
wr_en  out  1  to FIFO wr_en
wr_data  out  WIDTH  to FIFO wr_data
full  in  1  from FIFO full
wr_er  in  1  from FIFO wr_er; registered high the cycle after a rejected write
err_cnt  out  CNTW  saturating count of wr_er pulses

Behaviour:
- Reset (rst=0, asynchronous) forces the following, immediately and including mid-burst: state=IDLE, gnt=0, ack=0, wr_en=0, wr_data=0, busy=0, owner=0, beat=0, err_cnt=0, last=NREQ-1. Requester 0 therefore has first priority after reset.
- FSM states:
  - IDLE:
    - If any req bit is 1, select the first set bit searching upward from (last+1) mod NREQ with wrap-around.
    - On the next edge: gnt=onehot(sel), owner=sel, beat=0, state=XFER.
    - Arbitration latency is 1 cycle from req to gnt.
  - XFER:
    - Combinational write term: wr_en = req[owner] & ~full.
    - wr_data = req_data slice of owner when wr_en=1, otherwise 0.
    - ack = gnt when wr_en=1, otherwise 0.
    - Each write increments beat.
    - Exit to IDLE on the edge where either (a) wr_en=1 and beat==BURST-1, or (b) req[owner]=0.
    - On exit: gnt=0, last=owner. owner holds its value.
    - There is exactly one dead (IDLE) cycle between tenures.
- full=1 in XFER: no write, beat holds, grant is held. There is no timeout; the tenure continues once full drops.
- Simultaneous req[owner] drop and full=1: no write, exit per (b).
- Requests from non-owners are ignored during XFER and never acked. Data must be held stable until ack.
- A requester whose req is still set at tenure end is considered last in the next arbitration, which gives fairness.
- err_cnt increments by 1 on every clk edge where wr_er=1 and saturates at 2^CNTW-1. It is cleared only by reset.
- busy = (state==XFER).
- No combinational path from full to gnt; gnt, owner, busy and err_cnt are registered.

Test Plan:
- Reset then single requester: req=4'b0001, data 8'hA0..A5, full=0 -> gnt=0001 one cycle after req. Writes A0,A1,A2,A3 on 4 consecutive cycles, then gnt=0 for 1 cycle, then re-grant and write A4,A5.
- Round-robin: req=4'b1111 held, BURST=4 -> grant order 0,1,2,3,0. Exactly 4 acks per tenure, one idle cycle between tenures.
- Backpressure: requester 2 granted, full=1 for cycles 3-6 of the tenure -> wr_en=0 and ack=0 during those cycles, gnt stays 0100. The burst completes with 4 total writes after full drops.
- Early release: requester 1 drops req after 2 acks -> FSM returns to IDLE, last=1, and the next pending requester 3 (req=1010) is granted next.
- Error counting: pulse wr_er high for 3 cycles -> err_cnt=3. With CNTW=2, 5 pulses -> err_cnt saturates at 3.
- Async reset mid-burst: assert rst=0 between clock edges during XFER -> gnt, ack and wr_en go to 0 without a clock edge. After release, requester 0 wins first when req=1111.
